uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 8-bit entries (power of 2, 4..256).
REQ-002 SHALL have parameter AW, default 4, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  write request from the register interface.
REQ-006 SHALL have port wr_data  input  8  byte to enqueue.
REQ-007 SHALL have port flush  input  1  synchronous clear of contents.
REQ-008 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-009 SHALL have port rd_en  input  1  pop request from the TX state machine (its FIFO read-enable output).
REQ-010 SHALL have port rd_data  output  8  head entry, first-word-fall-through, feeds TX state machine payload input.
REQ-011 SHALL have port empty  output  1  no entries; drives TX state machine FIFO-empty input.
REQ-012 SHALL have port full  output  1  DEPTH entries held.
REQ-013 SHALL have port level  output  AW+1  current entry count, 0..DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky: write attempted while full.
REQ-015 SHALL have port underflow  output  1  sticky: read attempted while empty.

Function
REQ-016 SHALL store entries in an array indexed by wr_ptr and rd_ptr (AW bits each), wrapping modulo DEPTH.
REQ-017 SHALL accept a write (store wr_data at wr_ptr, wr_ptr+1) on a rising edge with wr_en=1 and full=0.
REQ-018 SHALL accept a pop (rd_ptr+1) on a rising edge with rd_en=1 and empty=0.
REQ-019 SHALL drive rd_data combinationally from array[rd_ptr] when empty=0, and 8'h00 when empty=1; the TX state machine samples rd_data in the same cycle it asserts rd_en.
REQ-020 SHALL make a written byte visible on rd_data, with empty=0, in the cycle after the write edge (write-to-read latency 1 cycle, no bypass).
REQ-021 SHALL derive empty = (level==0) and full = (level==DEPTH) from a registered count.
REQ-022 SHALL, on simultaneous accepted write and pop, leave level unchanged; when full, both succeed.
REQ-023 SHALL, when empty, accept wr_en while ignoring a simultaneous rd_en and setting underflow.
REQ-024 SHALL drop wr_data and set overflow on wr_en=1 with full=1 and no simultaneous pop.
REQ-025 SHALL set underflow on rd_en=1 with empty=1; pointers unchanged.
REQ-026 SHALL, on flush=1, zero wr_ptr, rd_ptr and level at the next edge, overriding same-cycle wr_en/rd_en; sticky flags unaffected.
REQ-027 SHALL clear overflow/underflow on clr_err=1; a same-cycle error event wins (flag set).
REQ-028 SHALL keep wr_ptr-rd_ptr modulo DEPTH consistent with level at all times, including across wrap.

Reset
REQ-029 SHALL, on rst_n=0, immediately set wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, rd_data=8'h00, overflow=0, underflow=0 (and irq_level=0 when compiled in).
REQ-030 SHALL not reset array contents; reset mid-transfer discards all queued bytes.

Configuration
REQ-031 SHALL, when macro UART_TXFIFO_LEVEL_IRQ_EN is defined, add input thresh (AW+1) and output irq_level (1), irq_level registered as (level <= thresh), updating one cycle after level changes.
REQ-032 SHALL, when UART_TXFIFO_LEVEL_IRQ_EN is undefined, omit thresh and irq_level ports and logic entirely; all other behaviour identical.

Verification
REQ-033 SHALL verify: reset, write 8'hA5 -> next cycle empty=0, level=1, rd_data=8'hA5; rd_en one cycle -> empty=1, rd_data=8'h00.
REQ-034 SHALL verify: DEPTH=16, write 0x00..0x0F -> full=1, level=16; 17th write 0xFF -> overflow=1, level=16; pop all -> 0x00..0x0F in order.
REQ-035 SHALL verify: 40 bytes streamed with interleaved/simultaneous write+pop -> order preserved across pointer wrap, level never exceeds 16, no error flags.
REQ-036 SHALL verify: rd_en while empty -> underflow=1; clr_err -> underflow=0; clr_err coincident with new underflow -> underflow stays 1.
REQ-037 SHALL verify: level=5, flush with wr_en=1 same cycle -> next cycle level=0, empty=1; rst_n pulse mid-stream -> all outputs at reset values immediately.
REQ-038 SHALL verify (UART_TXFIFO_LEVEL_IRQ_EN): thresh=2, level 3->2 -> irq_level=1 one cycle later; write to level 3 -> irq_level=0 one cycle later.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the UART register interface and the TX state machine.
// The head entry is presented first-word-fall-through on rd_data. A registered entry
// count drives empty/full/level. Sticky overflow/underflow flags record misuse until
// they are cleared with clr_err.
// Optional feature: define UART_TXFIFO_LEVEL_IRQ_EN to add the thresh input and the
// registered irq_level output, which is high while (level <= thresh).
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          clr_err,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
`ifdef UART_TXFIFO_LEVEL_IRQ_EN
  input  logic [AW:0]   thresh,
  output logic          irq_level,
`endif
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic          overflow_q;
  logic          underflow_q;
  logic          do_write;
  logic          do_pop;
  logic          overflow_event;
  logic          underflow_event;

  assign level = level_q;
  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LEVEL);

  // Head entry falls through; an empty FIFO shows zero instead of stale array contents.
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Decide which requests take effect this cycle; a flush suppresses everything else,
  // and a write while full still succeeds if the same edge pops a byte to make room.
  always_comb begin
    do_pop          = 1'b0;
    do_write        = 1'b0;
    overflow_event  = 1'b0;
    underflow_event = 1'b0;
    if (!flush) begin
      do_pop          = rd_en && !empty;
      do_write        = wr_en && (!full || rd_en);
      overflow_event  = wr_en && full && !rd_en;
      underflow_event = rd_en && empty;
    end
  end

  // Storage array is deliberately left without reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and entry count move together so wr_ptr-rd_ptr always matches level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_write && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (do_pop && !do_write) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // Sticky error flags: clr_err clears them, but an error in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (overflow_event) begin
        overflow_q <= 1'b1;
      end else if (clr_err) begin
        overflow_q <= 1'b0;
      end
      if (underflow_event) begin
        underflow_q <= 1'b1;
      end else if (clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

`ifdef UART_TXFIFO_LEVEL_IRQ_EN
  logic irq_q;
  assign irq_level = irq_q;

  // Low-level interrupt is registered from the count, so it trails level by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (level_q <= thresh);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed stimulus for uart_tx_fifo, checked against
// a queue-based reference model of the FIFO contents and sticky flags.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          flush;
  logic          clr_err;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          overflow;
  logic          underflow;
`ifdef UART_TXFIFO_LEVEL_IRQ_EN
  logic [AW:0]   thresh;
  logic          irq_level;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] model_q [$];
  bit         model_ovf = 0;
  bit         model_unf = 0;
  bit         model_irq = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .clr_err   (clr_err),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .level     (level),
`ifdef UART_TXFIFO_LEVEL_IRQ_EN
    .thresh    (thresh),
    .irq_level (irq_level),
`endif
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Compare every output against the model's view of the FIFO.
  task automatic checkAll(input string tag);
    int n;
    n = model_q.size();
    checkOutput({tag, ".level"}, 32'(level), 32'(n));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(n == 0));
    checkOutput({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    checkOutput({tag, ".rd_data"}, 32'(rd_data), (n > 0) ? 32'(model_q[0]) : 32'h0);
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(model_ovf));
    checkOutput({tag, ".underflow"}, 32'(underflow), 32'(model_unf));
`ifdef UART_TXFIFO_LEVEL_IRQ_EN
    checkOutput({tag, ".irq_level"}, 32'(irq_level), 32'(model_irq));
`endif
  endtask

  // Advance the model by one clock edge using the inputs applied during that cycle.
  task automatic modelStep(input bit wr, input logic [7:0] d, input bit rd, input bit fl, input bit clr);
    int  n;
    bit  pop_ok;
    bit  wr_ok;
    bit  ovf_ev;
    bit  unf_ev;
    n = model_q.size();
`ifdef UART_TXFIFO_LEVEL_IRQ_EN
    model_irq = (n <= int'(thresh));
`endif
    if (fl) begin
      model_q.delete();
      ovf_ev = 0;
      unf_ev = 0;
    end else begin
      pop_ok = rd && (n > 0);
      wr_ok  = wr && ((n - int'(pop_ok)) < DEPTH);
      ovf_ev = wr && !wr_ok;
      unf_ev = rd && (n == 0);
      if (pop_ok) void'(model_q.pop_front());
      if (wr_ok) model_q.push_back(d);
    end
    model_ovf = ovf_ev ? 1'b1 : (clr ? 1'b0 : model_ovf);
    model_unf = unf_ev ? 1'b1 : (clr ? 1'b0 : model_unf);
  endtask

  // Drive one cycle of inputs, let the edge happen, then check on the falling edge.
  task automatic applyStimulus(input string tag, input bit wr, input logic [7:0] d,
                               input bit rd, input bit fl, input bit clr);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    flush   = fl;
    clr_err = clr;
    @(posedge clk);
    modelStep(wr, d, rd, fl, clr);
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
    checkAll(tag);
  endtask

  task automatic modelReset();
    model_q.delete();
    model_ovf = 0;
    model_unf = 0;
    model_irq = 0;
  endtask

  initial begin
    logic [7:0] next_byte;
    int         streamed;
    bit         w;
    bit         r;
    bit         f;

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    flush   = 1'b0;
    clr_err = 1'b0;
    rd_en   = 1'b0;
`ifdef UART_TXFIFO_LEVEL_IRQ_EN
    thresh  = 5'd2;
`endif
    modelReset();
    repeat (2) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkAll("post_reset");

    $display("[TB] single byte write and pop");
    applyStimulus("wr_a5", 1, 8'hA5, 0, 0, 0);
    checkOutput("wr_a5.data_const", 32'(rd_data), 32'hA5);
    checkOutput("wr_a5.level_const", 32'(level), 32'd1);
    applyStimulus("pop_a5", 0, 8'h00, 1, 0, 0);
    checkOutput("pop_a5.empty_const", 32'(empty), 32'd1);
    checkOutput("pop_a5.data_const", 32'(rd_data), 32'h00);

    $display("[TB] fill to full and overflow");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus("fill", 1, 8'(i), 0, 0, 0);
    end
    checkOutput("fill.full_const", 32'(full), 32'd1);
    checkOutput("fill.level_const", 32'(level), 32'd16);
    applyStimulus("ovf_wr", 1, 8'hFF, 0, 0, 0);
    checkOutput("ovf_wr.flag_const", 32'(overflow), 32'd1);
    checkOutput("ovf_wr.level_const", 32'(level), 32'd16);
    applyStimulus("full_wr_pop", 1, 8'h5C, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("drain.order", 32'(rd_data), (i < DEPTH - 1) ? 32'(i + 1) : 32'h5C);
      applyStimulus("drain", 0, 8'h00, 1, 0, 0);
    end
    applyStimulus("clr_ovf", 0, 8'h00, 0, 0, 1);
    checkOutput("clr_ovf.const", 32'(overflow), 32'd0);

    $display("[TB] streaming 40 bytes across pointer wrap");
    next_byte = 8'h30;
    streamed  = 0;
    for (int c = 0; c < 400 && streamed < 40; c++) begin
      w = ($urandom_range(0, 99) < 60) && (model_q.size() < DEPTH);
      r = ($urandom_range(0, 99) < 50) && (model_q.size() > 0);
      applyStimulus("stream", w, next_byte, r, 0, 0);
      if (w) begin
        next_byte++;
        streamed++;
      end
    end
    checkOutput("stream.count", 32'(streamed), 32'd40);
    while (model_q.size() > 0) begin
      applyStimulus("stream_drain", 0, 8'h00, 1, 0, 0);
    end

    $display("[TB] underflow and clr_err");
    applyStimulus("unf", 0, 8'h00, 1, 0, 0);
    checkOutput("unf.const", 32'(underflow), 32'd1);
    applyStimulus("unf_clr", 0, 8'h00, 0, 0, 1);
    checkOutput("unf_clr.const", 32'(underflow), 32'd0);
    applyStimulus("unf_clr_race", 0, 8'h00, 1, 0, 1);
    checkOutput("unf_clr_race.const", 32'(underflow), 32'd1);
    applyStimulus("empty_wr_rd", 1, 8'h77, 1, 0, 1);
    checkOutput("empty_wr_rd.data", 32'(rd_data), 32'h77);
    applyStimulus("clr_all", 0, 8'h00, 1, 0, 1);

    $display("[TB] flush and asynchronous reset");
    for (int i = 0; i < 5; i++) begin
      applyStimulus("pre_flush", 1, 8'(8'hC0 + i), 0, 0, 0);
    end
    checkOutput("pre_flush.level_const", 32'(level), 32'd5);
    applyStimulus("flush_wr", 1, 8'hEE, 0, 1, 0);
    checkOutput("flush_wr.level_const", 32'(level), 32'd0);
    checkOutput("flush_wr.empty_const", 32'(empty), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("pre_rst", 1, 8'(8'h90 + i), 0, 0, 0);
    end
    applyStimulus("pre_rst_ovf", 0, 8'h00, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkAll("after_rst");

`ifdef UART_TXFIFO_LEVEL_IRQ_EN
    $display("[TB] level interrupt");
    thresh = 5'd2;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("irq_fill", 1, 8'(i), 0, 0, 0);
    end
    applyStimulus("irq_settle", 0, 8'h00, 0, 0, 0);
    checkOutput("irq_at3.const", 32'(irq_level), 32'd0);
    applyStimulus("irq_pop", 0, 8'h00, 1, 0, 0);
    checkOutput("irq_pop.lag_const", 32'(irq_level), 32'd0);
    applyStimulus("irq_idle", 0, 8'h00, 0, 0, 0);
    checkOutput("irq_idle.const", 32'(irq_level), 32'd1);
    applyStimulus("irq_wr", 1, 8'h44, 0, 0, 0);
    checkOutput("irq_wr.lag_const", 32'(irq_level), 32'd1);
    applyStimulus("irq_idle2", 0, 8'h00, 0, 0, 0);
    checkOutput("irq_idle2.const", 32'(irq_level), 32'd0);
    applyStimulus("irq_flush", 0, 8'h00, 0, 1, 0);
    thresh = 5'($urandom_range(0, DEPTH));
`endif

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      f = ($urandom_range(0, 99) < 3);
      w = !f && ($urandom_range(0, 99) < 55);
      r = !f && ($urandom_range(0, 99) < 45);
      applyStimulus("random", w, 8'($urandom), r, f, ($urandom_range(0, 99) < 10));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
